// File: rtl/clkmgr_clk_status_grp.sv
// Clock group status monitor: synchronises per-clock enables, classifies each
// group as all-on / all-off / mixed, debounces status with a programmable filter,
// flags long mixed episodes (sticky err_o) and pulses status_chg_o on transitions.
// Ports: clk_i/rst_ni monitor clock and async active-low reset; ens_i raw
// group-major enables; filter_i stable-cycle count; err_clr_i per-group error clear;
// status_o, status_chg_o, err_o per-group results.

// Two-stage synchroniser for signals arriving from foreign clock domains.
module prim_flop_2sync #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1, stage2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= d_i;
      stage2 <= stage1;
    end
  end

  assign q_o = stage2;

endmodule

module clkmgr_clk_status_grp #(
  parameter int unsigned NumGroups     = 2,
  parameter int unsigned NumClocks     = 4,
  parameter int unsigned MaxFilter     = 15,
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned FiltW         = $clog2(MaxFilter + 1),
  parameter int unsigned CntW          =
    $clog2(((MaxFilter > TimeoutCycles) ? MaxFilter : TimeoutCycles) + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumGroups*NumClocks-1:0] ens_i,
  input  logic [FiltW-1:0]               filter_i,
  input  logic [NumGroups-1:0]           err_clr_i,
  output logic [NumGroups-1:0]           status_o,
  output logic [NumGroups-1:0]           status_chg_o,
  output logic [NumGroups-1:0]           err_o
);

  localparam int unsigned TotalW = NumGroups * NumClocks;
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
  localparam logic [CntW-1:0] TimeoutThr = CntW'(TimeoutCycles);
  localparam logic [FiltW-1:0] FiltMax   = FiltW'(MaxFilter);

  typedef enum logic [1:0] {
    CLS_OFF = 2'd0,
    CLS_ON  = 2'd1,
    CLS_MIX = 2'd2
  } cls_e;

  logic [TotalW-1:0] ens_sync;

  prim_flop_2sync #(
    .Width(TotalW)
  ) u_ens_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (ens_i),
    .q_o   (ens_sync)
  );

  // Zero filter means "commit on the first settled cycle"; out-of-range values
  // are clamped so a bad register write cannot stall the monitor.
  logic [CntW-1:0] filt_eff;

  always_comb begin
    filt_eff = CntW'(filter_i);
    if (filter_i == '0) begin
      filt_eff = CntW'(1);
    end else if (filter_i > FiltMax) begin
      filt_eff = CntW'(FiltMax);
    end
  end

  for (genvar g = 0; g < NumGroups; g++) begin : g_grp
    logic [NumClocks-1:0] ens_g;
    cls_e                 cls_d, cls_q;
    logic [CntW-1:0]      cnt_d, cnt_q;
    logic                 status_d, status_q;
    logic                 chg_q, err_q, err_set;

    assign ens_g = ens_sync[g*NumClocks +: NumClocks];

    always_comb begin
      if (&ens_g) begin
        cls_d = CLS_ON;
      end else if (~|ens_g) begin
        cls_d = CLS_OFF;
      end else begin
        cls_d = CLS_MIX;
      end
    end

    // Counts consecutive cycles in the current class; saturation keeps the
    // timeout compare from firing again within one mixed episode.
    always_comb begin
      cnt_d = cnt_q;
      if (cls_d != cls_q) begin
        cnt_d = CntW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_comb begin
      status_d = status_q;
      if (cnt_d >= filt_eff) begin
        if (cls_d == CLS_ON) begin
          status_d = 1'b1;
        end else if (cls_d == CLS_OFF) begin
          status_d = 1'b0;
        end
      end
    end

    assign err_set = (cls_d == CLS_MIX) && (cnt_d == TimeoutThr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cls_q    <= CLS_OFF;
        cnt_q    <= '0;
        status_q <= 1'b0;
        chg_q    <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        cls_q    <= cls_d;
        cnt_q    <= cnt_d;
        status_q <= status_d;
        chg_q    <= status_d != status_q;
        // A set on the same edge as a clear takes priority.
        if (err_set) begin
          err_q <= 1'b1;
        end else if (err_clr_i[g]) begin
          err_q <= 1'b0;
        end
      end
    end

    assign status_o[g]     = status_q;
    assign status_chg_o[g] = chg_q;
    assign err_o[g]        = err_q;
  end

endmodule

// File: tb/tb_clkmgr_clk_status_grp.sv
// Directed testbench for clkmgr_clk_status_grp with default parameters
// (2 groups x 4 clocks, MaxFilter 15, TimeoutCycles 64).
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_clkmgr_clk_status_grp;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] ens_i;
  logic [3:0] filter_i;
  logic [1:0] err_clr_i;
  logic [1:0] status_o;
  logic [1:0] status_chg_o;
  logic [1:0] err_o;

  int vectors;
  int miscompares;

  clkmgr_clk_status_grp dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ens_i       (ens_i),
    .filter_i    (filter_i),
    .err_clr_i   (err_clr_i),
    .status_o    (status_o),
    .status_chg_o(status_chg_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_ni      = 1'b0;
    ens_i       = 8'h00;
    filter_i    = 4'd3;
    err_clr_i   = 2'b00;

    // Reset state
    #2;
    chk("rst_status", 32'(status_o), 32'h0);
    chk("rst_chg", 32'(status_chg_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(6);
    chk("idle_status", 32'(status_o), 32'h0);

    // Group 0 turns fully on, filter 3: status rises at edge 5
    ens_i = 8'h0F;
    tick(4);
    chk("on_e4_status", 32'(status_o), 32'h0);
    tick(1);
    chk("on_e5_status", 32'(status_o), 32'h1);
    chk("on_e5_chg", 32'(status_chg_o), 32'h1);
    tick(1);
    chk("on_e6_chg", 32'(status_chg_o), 32'h0);
    chk("on_e6_status", 32'(status_o), 32'h1);

    // Two-cycle glitch on one clock of group 0 is filtered out
    ens_i = 8'h0E;
    tick(2);
    ens_i = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk("glitch_status", 32'(status_o), 32'h1);
      chk("glitch_chg", 32'(status_chg_o), 32'h0);
      chk("glitch_err", 32'(err_o), 32'h0);
      tick(1);
    end

    // Group 1 mixed: first mixed compare at edge 3, timeout at edge 66
    ens_i = 8'hAF;
    tick(65);
    chk("mix_e65_err", 32'(err_o), 32'h0);
    tick(1);
    chk("mix_e66_err", 32'(err_o), 32'h2);
    chk("mix_e66_status", 32'(status_o), 32'h1);

    // Clear while still mixed: saturated counter prevents re-set
    err_clr_i = 2'b10;
    tick(1);
    err_clr_i = 2'b00;
    chk("clr_err", 32'(err_o), 32'h0);
    tick(80);
    chk("clr_hold_err", 32'(err_o), 32'h0);

    // Group 1 on, then mixed again; clear collides with the set edge
    ens_i = 8'hFF;
    tick(5);
    chk("g1_on_status", 32'(status_o), 32'h3);
    chk("g1_on_chg", 32'(status_chg_o), 32'h2);
    ens_i = 8'hAF;
    tick(65);
    chk("mix2_e65_err", 32'(err_o), 32'h0);
    err_clr_i = 2'b10;
    tick(1);
    err_clr_i = 2'b00;
    chk("mix2_setwins_err", 32'(err_o), 32'h2);
    chk("mix2_status", 32'(status_o), 32'h3);
    err_clr_i = 2'b10;
    tick(1);
    err_clr_i = 2'b00;
    chk("mix2_clr_err", 32'(err_o), 32'h0);

    // filter 0 behaves as 1: group 0 off commits at edge 3
    filter_i = 4'd0;
    ens_i    = 8'hA0;
    tick(2);
    chk("f0_e2_status", 32'(status_o), 32'h3);
    tick(1);
    chk("f0_e3_status", 32'(status_o), 32'h2);
    chk("f0_e3_chg", 32'(status_chg_o), 32'h1);

    // filter 15: a 14-cycle on pulse never commits
    filter_i = 4'd15;
    tick(4);
    ens_i = 8'hAF;
    tick(14);
    ens_i = 8'hA0;
    for (int i = 0; i < 20; i++) begin
      chk("p14_status", 32'(status_o), 32'h2);
      chk("p14_chg", 32'(status_chg_o), 32'h0);
      tick(1);
    end

    // filter 15: a sustained on commits at edge 17
    ens_i = 8'hAF;
    tick(16);
    chk("f15_e16_status", 32'(status_o), 32'h2);
    tick(1);
    chk("f15_e17_status", 32'(status_o), 32'h3);
    chk("f15_e17_chg", 32'(status_chg_o), 32'h1);

    // Reset in mid-count clears everything at once
    filter_i = 4'd3;
    ens_i    = 8'hFF;
    tick(2);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_status", 32'(status_o), 32'h0);
    chk("arst_chg", 32'(status_chg_o), 32'h0);
    chk("arst_err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(4);
    chk("post_rst_e4_status", 32'(status_o), 32'h0);
    tick(1);
    chk("post_rst_e5_status", 32'(status_o), 32'h3);
    chk("post_rst_e5_chg", 32'(status_chg_o), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clkmgr_clk_status_grp.md
Name: clkmgr_clk_status_grp

Overview:
Multi-group clock enable/disable status monitor for the clock manager. It synchronises per-clock enable indications from foreign clock domains and classifies each group as all-on, all-off or mixed. Each group's status is debounced with a runtime-programmable filter count. It also flags groups that stay mixed too long, and emits status-change pulses for interrupt and alert logic.

Parameters:
NumGroups, 2, number of independent clock families monitored
NumClocks, 4, clocks per group; ens_i is group-major, group g occupies bits [g*NumClocks +: NumClocks]
MaxFilter, 15, largest legal filter count
TimeoutCycles, 64, consecutive mixed cycles before err_o asserts (>=1)
FiltW, $clog2(MaxFilter+1), width of filter_i
CntW, $clog2(max(MaxFilter,TimeoutCycles)+1), stability counter width

Ports:
clk_i  in  1  monitor clock
rst_ni  in  1  reset, asynchronous, active-low
ens_i  in  NumGroups*NumClocks  raw enable indications, asynchronous to clk_i
filter_i  in  FiltW  required consecutive stable cycles; quasi-static, in clk_i domain
err_clr_i  in  NumGroups  per-group clear of sticky timeout error
status_o  out  NumGroups  1 = group fully enabled, 0 = fully disabled
status_chg_o  out  NumGroups  one-cycle pulse on any status_o transition
err_o  out  NumGroups  sticky: group stayed mixed for TimeoutCycles

Behaviour:
- Reset:
  - All flops reset to 0: sync stages, class, counters, status_o, status_chg_o, err_o.
  - Reset class = OFF.
  - Reset mid-operation aborts all counting immediately.
- Synchronisation: ens_i passes through a 2-flop synchroniser (prim_flop_2sync, Width=NumGroups*NumClocks) to give ens_sync.
- Classification per group, combinational on ens_sync:
  - ON if all bits are 1.
  - OFF if all bits are 0.
  - MIX otherwise.
- Effective filter: F = (filter_i==0) ? 1 : min(filter_i, MaxFilter).
- Stability counter per group:
  - cls_d != cls_q: cnt_d = 1.
  - Otherwise: cnt_d = cnt_q+1, saturating at 2^CntW-1.
  - cls_q <= cls_d and cnt_q <= cnt_d every cycle.
- Status update, on the edge where the registered values take effect:
  - cls_d==ON and cnt_d>=F: status_o <= 1.
  - cls_d==OFF and cnt_d>=F: status_o <= 0.
  - Otherwise (MIX or unsettled) status_o holds.
- Latency: ens_i stable before edge 1 -> status_o updates at edge 2+F. Glitches shorter than F synced cycles never change status_o.
- status_chg_o:
  - Registered; high for exactly the one cycle after status_o changes value (the cycle following the update edge).
  - No pulse when status_o is re-asserted to its current value.
- Timeout error:
  - err_o[g] <= 1 on the edge where cls_d==MIX and cnt_d==TimeoutCycles.
  - Exactly one set event per mixed episode; the saturating counter prevents retrigger.
  - err_clr_i[g] clears err_o[g] on the next edge.
  - Simultaneous set and clear: set wins.
  - err_o has no effect on status_o.
- filter_i changes take effect combinationally on the next compare. Raising F mid-count extends the wait; lowering F below the current cnt commits on the next edge, provided the class is still stable.
- Groups are fully independent; no cross-group coupling.
- NumClocks==1: MIX is unreachable and err_o stays 0.

Test Plan:
- Reset, then ens_i all 1 in group 0, filter_i=3 -> status_o[0] rises at edge 5; status_chg_o[0] pulses one cycle; status_o[1] stays 0.
- Group 0 on, ens_i[0] driven low for 2 synced cycles with filter_i=3 -> status_o[0] stays 1, no status_chg_o pulse, err_o stays 0.
- Group 1 held mixed (1010) with TimeoutCycles=64 -> err_o[1] sets exactly 64 cycles after the first synced mixed cycle; status_o[1] unchanged.
- err_o[1] set, err_clr_i[1] pulsed while the group is still mixed -> err_o[1] clears and does not re-set (counter saturated). Then go ON->MIX again -> err_o[1] re-sets after 64 cycles.
- filter_i=0 -> behaves as 1: status follows at edge 3. filter_i=15 with a 14-cycle pulse -> no change.
- rst_ni asserted while cnt is mid-count and status_o=1 -> all outputs 0 immediately. After release with ens_i all 1 -> status_o rises at edge 2+F.
